// File: rtl/controle_botoes_pkg.sv
// Shared constants and types for the LED-matrix map selector buttons.
// Holds the button index map, the default timing/map parameters and the
// wrap-around helpers used when stepping through maps.
package controle_botoes_pkg;

   // Button positions inside the 4-bit btn / pressed vectors
   localparam int BTN_PROX  = 0;
   localparam int BTN_ANT   = 1;
   localparam int BTN_HOME  = 2;
   localparam int BTN_PAUSA = 3;
   localparam int NUM_BTN   = 4;

   // Default parameter values for the top level
   localparam int DEF_DEBOUNCE_TICKS = 4;
   localparam int DEF_NUM_MAPAS      = 5;
   localparam int DEF_AUTO_TICKS     = 762;

   // Map index wide enough for up to 8 maps
   localparam int SEL_W = 3;
   typedef logic [SEL_W-1:0] sel_t;

   // Next map, wrapping from the last map back to 0
   function automatic sel_t sel_inc(input sel_t s, input int n);
      return (s == sel_t'(n - 1)) ? '0 : s + sel_t'(1);
   endfunction

   // Previous map, wrapping from 0 to the last map
   function automatic sel_t sel_dec(input sel_t s, input int n);
      return (s == '0) ? sel_t'(n - 1) : s - sel_t'(1);
   endfunction

endpackage

// File: rtl/controle_botoes_if.sv
// Button-controller bundle: tick enable and raw buttons in, map index,
// press pulses and pause flag out. master = stimulus side, slave = controller.
// No handshake: every signal is sampled or produced once per clock.
interface controle_botoes_if;
   import controle_botoes_pkg::*;

   logic               tick;
   logic [NUM_BTN-1:0] btn;
   sel_t               sel;
   logic [NUM_BTN-1:0] pressed;
   logic               pausado;

   modport master (output tick, btn, input sel, pressed, pausado);
   modport slave  (input tick, btn, output sel, pressed, pausado);

endinterface

// File: rtl/controle_botoes_debounce_botao.sv
// Single-button conditioner: 2-flop synchronizer, tick-based debounce, press pulse.
// Latency: 2 clocks sync + DEBOUNCE_TICKS ticks to stable level, +1 clock to pulse.
// No backpressure: the one-clock press pulse is produced unconditionally.
module debounce_botao
   import controle_botoes_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
   input  logic clock,
   input  logic reset,
   input  logic tick,
   input  logic btn,
   output logic pressed
);

   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

   logic [1:0]       sync_q;
   logic             nivel_sync;
   logic [CNT_W-1:0] cnt_q;
   logic             stable_q;
   logic             stable_dly_q;

   assign nivel_sync = sync_q[1];

   // Two-flop synchronizer; resets to the released (high) level
   always_ff @(posedge clock) begin
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], btn};
   end

   // Debounce: count ticks while the level disagrees, adopt it after DEBOUNCE_TICKS
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         stable_q <= 1'b1;
      end else if (nivel_sync == stable_q) begin
         cnt_q <= '0;
      end else if (tick) begin
         if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
            stable_q <= nivel_sync;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Pulse for one clock after the stable level falls; releases are ignored
   always_ff @(posedge clock) begin
      if (reset) begin
         stable_dly_q <= 1'b1;
         pressed      <= 1'b0;
      end else begin
         stable_dly_q <= stable_q;
         pressed      <= stable_dly_q & ~stable_q;
      end
   end

endmodule

// File: rtl/controle_botoes.sv
// Map selector: four debounced buttons step/home the LED-matrix map index (AUTO_SCROLL_EN adds auto-advance + pause).
// Latency: button edge to sel update = 2 sync clocks + DEBOUNCE_TICKS ticks + 2 clocks.
// No backpressure: sel updates on the clock after each accepted press pulse.
module controle_botoes
   import controle_botoes_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int NUM_MAPAS      = DEF_NUM_MAPAS,
   parameter int AUTO_TICKS     = DEF_AUTO_TICKS
) (
   input logic              clock,
   input logic              reset,
   controle_botoes_if.slave bus
);

   // Reject unusable configurations at elaboration
   if (NUM_MAPAS < 2 || NUM_MAPAS > 8 || DEBOUNCE_TICKS < 1 || AUTO_TICKS < 1) begin : g_param_err
      $error("controle_botoes: parameter out of range");
   end

   logic [NUM_BTN-1:0] pressed;
   sel_t               sel_q;
   sel_t               sel_manual;
   logic               manual;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      debounce_botao #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
      ) u_debounce (
         .clock   (clock),
         .reset   (reset),
         .tick    (bus.tick),
         .btn     (bus.btn[i]),
         .pressed (pressed[i])
      );
   end

   // Any navigation pulse (including next+previous together) counts as manual
   assign manual = pressed[BTN_PROX] | pressed[BTN_ANT] | pressed[BTN_HOME];

   // Manual target: home wins, next+previous cancel, otherwise step once
   always_comb begin
      sel_manual = sel_q;
      if (pressed[BTN_HOME])
         sel_manual = '0;
      else if (pressed[BTN_PROX] && !pressed[BTN_ANT])
         sel_manual = sel_inc(sel_q, NUM_MAPAS);
      else if (pressed[BTN_ANT] && !pressed[BTN_PROX])
         sel_manual = sel_dec(sel_q, NUM_MAPAS);
   end

`ifdef AUTO_SCROLL_EN
   localparam int AUTO_W = $clog2(AUTO_TICKS + 1);

   logic [AUTO_W-1:0] auto_cnt_q;
   logic              pausado_q;
   logic              auto_fire;

   assign auto_fire = bus.tick && !pausado_q && (auto_cnt_q == AUTO_W'(AUTO_TICKS - 1));

   // Pause toggles on each accepted press of the pause button
   always_ff @(posedge clock) begin
      if (reset)                   pausado_q <= 1'b0;
      else if (pressed[BTN_PAUSA]) pausado_q <= ~pausado_q;
   end

   // Tick counter for auto-advance; frozen while paused, restarted by manual navigation
   always_ff @(posedge clock) begin
      if (reset || manual)
         auto_cnt_q <= '0;
      else if (bus.tick && !pausado_q)
         auto_cnt_q <= auto_fire ? '0 : auto_cnt_q + AUTO_W'(1);
   end

   assign bus.pausado = pausado_q;
`else
   assign bus.pausado = 1'b0;
`endif

   // Map index register; manual pulses take priority over auto-advance
   always_ff @(posedge clock) begin
      if (reset)
         sel_q <= '0;
      else if (manual)
         sel_q <= sel_manual;
`ifdef AUTO_SCROLL_EN
      else if (auto_fire)
         sel_q <= sel_inc(sel_q, NUM_MAPAS);
`endif
   end

   assign bus.sel     = sel_q;
   assign bus.pressed = pressed;

endmodule

// File: doc/controle_botoes.md
CONTROLE_BOTOES -- requirements
Module: controle_botoes

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 4: number of consecutive tick pulses a button level must hold before it is accepted.
REQ-002 Parameter NUM_MAPAS, default 5: number of selectable LED-matrix maps (legal range 2..8).
REQ-003 Parameter AUTO_TICKS, default 762: ticks between automatic advances; used only when AUTO_SCROLL_EN is defined.
REQ-004 clock  input  1: single system clock; all logic is on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 tick  input  1: one-clock-wide enable pulse from the frequency divider (~1 kHz); all debounce timing uses it.
REQ-007 btn  input  4: raw asynchronous push-buttons, active-low (0 = pressed); btn[0] next, btn[1] previous, btn[2] home, btn[3] pause.
REQ-008 sel  output  3: current map index in 0..NUM_MAPAS-1; drives the map selector.
REQ-009 pressed  output  4: one-clock pulse per button on an accepted press.
REQ-010 pausado  output  1: pause state; constant 0 when AUTO_SCROLL_EN is undefined.

Function
REQ-011 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each button SHALL have its own debounce counter and stable level (stable 1 = released); the counter clears on any clock where the synchronized level equals the stable level.
REQ-013 On a tick where the synchronized level differs from the stable level, the counter SHALL increment; when it reaches DEBOUNCE_TICKS, the stable level takes the synchronized value and the counter clears.
REQ-014 pressed[i] SHALL pulse high for exactly one clock, in the clock after stable[i] goes 1->0; releases produce no pulse.
REQ-015 When pressed[0] is high, sel SHALL take sel+1 on the next clock, wrapping from NUM_MAPAS-1 to 0.
REQ-016 When pressed[1] is high, sel SHALL take sel-1 on the next clock, wrapping from 0 to NUM_MAPAS-1.
REQ-017 When pressed[2] is high, sel SHALL become 0 and override any other pressed pulse in the same clock.
REQ-018 When pressed[0] and pressed[1] are high in the same clock, sel SHALL not change.
REQ-019 Total latency from a clean btn press edge to the sel update SHALL be 2 sync clocks + DEBOUNCE_TICKS ticks + 2 clocks.
REQ-020 A bounce shorter than DEBOUNCE_TICKS ticks SHALL produce no pulse and no sel change.
REQ-021 A held button SHALL produce exactly one pulse; there is no auto-repeat.

Reset
REQ-022 While reset is high: sel = 0, pressed = 0, pausado = 0, all counters = 0, all stable levels = 1, and synchronizer flops = 1.
REQ-023 A reset asserted mid-debounce SHALL discard the partial count; a button still held after reset release is accepted as a new press after the full debounce.

Configuration
REQ-024 Macro AUTO_SCROLL_EN defined: a tick counter SHALL advance sel by +1 (with the REQ-015 wrap) every AUTO_TICKS ticks while pausado = 0.
REQ-025 With AUTO_SCROLL_EN defined, pressed[3] SHALL toggle pausado.
REQ-026 With AUTO_SCROLL_EN defined, any press on btn[0], btn[1] or btn[2] SHALL clear the auto counter.
REQ-027 With AUTO_SCROLL_EN defined, a manual pulse SHALL take priority over an auto advance in the same clock.
REQ-028 Macro AUTO_SCROLL_EN undefined: no auto counter is built, pausado = 0, and pressed[3] is still generated but has no other effect.

Structure
REQ-029 The button index constants (BTN_PROX=0, BTN_ANT=1, BTN_HOME=2, BTN_PAUSA=3) and the default DEBOUNCE_TICKS/NUM_MAPAS/AUTO_TICKS values SHALL live in the shared package.
REQ-030 One sub-module, debounce_botao, SHALL implement synchronizer, counter, stable level and press pulse for a single button and be instantiated 4 times.

Verification
REQ-031 Reset, then hold btn = 4'b1111 for 50 ticks -> sel = 0, pressed = 0 throughout.
REQ-032 Press btn[0] cleanly 6 times (each held 10 ticks, released 10 ticks) -> sel sequence 1,2,3,4,0,1; exactly one pressed[0] pulse per press.
REQ-033 After reset, press btn[1] once -> sel = 4; then bounce btn[1] with 2-tick low glitches (DEBOUNCE_TICKS = 4) -> no pulse, sel stays 4.
REQ-034 With sel = 3, force pressed[0] and pressed[2] in the same clock -> sel = 0; force pressed[0] and pressed[1] together -> sel unchanged.
REQ-035 Hold btn[0] low, assert reset for 3 clocks at debounce count 3, then release reset with btn[0] still low -> sel = 0, then sel = 1 exactly DEBOUNCE_TICKS ticks + 4 clocks later.
REQ-036 AUTO_SCROLL_EN defined with AUTO_TICKS = 10 -> sel increments every 10 ticks; press btn[3] -> pausado = 1 and sel frozen for 30 ticks; press btn[3] again -> auto advance resumes.
